and_test_sequencer: RTL and testbench
=====================================

AND_TEST_SEQUENCER -- requirements
Module: and_test_sequencer

Interface
REQ-001 Parameter DWELL, default 4: clock cycles each stimulus vector is held; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a test run; sampled only in IDLE or DONE.
REQ-005 dut_y  input  1  output of the 2-input AND gate under test.
REQ-006 i1  output  1  DUT input A, registered.
REQ-007 i2  output  1  DUT input B, registered.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until the next start or reset.
REQ-010 pass  output  1  valid while done; high iff err_count==0.
REQ-011 step  output  4  index of the vector currently driven, 0..11.
REQ-012 err_count  output  4  mismatches in the current run, saturating at 15.
REQ-013 mismatch  output  1  one-cycle pulse on the cycle a compare fails.

Function
REQ-014 Fixed 12-entry vector table (i1,i2) for steps 0..11 SHALL be: 10,11,01,00,10,11,01,00,01,11,01,00.
REQ-015 FSM states: IDLE, RUN, DONE; reset enters IDLE.
REQ-016 IDLE or DONE with start=1 SHALL go to RUN on the next edge, with step=0, dwell counter=0, err_count=0, i1/i2=table[0].
REQ-017 In RUN, the dwell counter SHALL increment each cycle; the compare SHALL occur on the cycle counter==DWELL-1.
REQ-018 Compare: expected = i1 AND i2 of the current step; dut_y!=expected SHALL pulse mismatch and increment err_count (hold at 15).
REQ-019 After the compare, step<11 SHALL advance step, reload counter to 0 and drive the next vector on the next edge.
REQ-020 After the compare at step 11, the FSM SHALL enter DONE, drive i1=i2=0 and hold step at 11.
REQ-021 done SHALL rise exactly 12*DWELL cycles after the edge that samples start.
REQ-022 busy=1 only in RUN; done=1 only in DONE; busy and done SHALL never both be high.
REQ-023 start in RUN SHALL be ignored.
REQ-024 start in DONE SHALL restart a run and clear done, pass and err_count on the same edge.
REQ-025 dut_y SHALL be ignored on all non-compare cycles.

Reset
REQ-026 Reset SHALL have priority over start and all other inputs.
REQ-027 Reset values: state IDLE, i1=0, i2=0, busy=0, done=0, pass=0, step=0, err_count=0, mismatch=0, counter=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; outputs SHALL take their reset values on the next edge.

Configuration
REQ-029 Macro AND_SEQ_STOP_ON_ERR_EN: when defined, the first mismatch SHALL end the run, entering DONE on the next edge with err_count=1 and step holding the failing index.
REQ-030 When AND_SEQ_STOP_ON_ERR_EN is undefined, all 12 vectors SHALL always run regardless of mismatches.

Verification
REQ-031 Correct AND DUT, DWELL=4, start pulse: done rises 48 cycles after start; err_count=0; pass=1; i1/i2 sequence matches REQ-014.
REQ-032 DUT stuck-at-0, macro off: mismatch at steps 1, 5 and 9; err_count=3; pass=0.
REQ-033 OR gate as DUT, macro off: mismatch at steps 0, 2, 4, 6, 8 and 10; err_count=6.
REQ-034 DUT stuck-at-0, macro on, DWELL=4: run stops after step 1; done rises 8 cycles after start; err_count=1; step=1.
REQ-035 Reset asserted at step 5: next edge gives IDLE with all reset values; a later start runs the full 48 cycles cleanly.
REQ-036 start held high throughout the run: no restart; start in DONE restarts with err_count cleared.

Source files
------------

// File: rtl/and_test_sequencer_if.sv
// and_test_sequencer_if -- signal bundle between the AND-gate test sequencer
// and its surroundings.
//   start      : begin a test run
//   dut_y      : output of the AND gate under test
//   i1, i2     : registered stimulus to the gate under test
//   busy, done : run in progress / run complete
//   pass       : valid while done, high when no mismatches were seen
//   step       : index of the vector currently driven (0..11)
//   err_count  : mismatches in the current run, saturating at 15
//   mismatch   : one-cycle pulse on a failing compare
// master = sequencer side, slave = controller / gate side.
interface and_test_sequencer_if;
  logic       start;
  logic       dut_y;
  logic       i1;
  logic       i2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] step;
  logic [3:0] err_count;
  logic       mismatch;

  modport master (
    input  start, dut_y,
    output i1, i2, busy, done, pass, step, err_count, mismatch
  );

  modport slave (
    output start, dut_y,
    input  i1, i2, busy, done, pass, step, err_count, mismatch
  );
endinterface

// File: rtl/and_test_sequencer.sv
// and_test_sequencer -- walks a fixed 12-entry (i1,i2) vector table into a
// 2-input AND gate, holds each vector DWELL cycles and compares the gate
// output on the last cycle of each dwell.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; priority over every other input
//   bus   : and_test_sequencer_if.master (start/dut_y in, status and stimulus out)
// Parameter DWELL (2..255): cycles each vector is held.
// Optional build macro AND_SEQ_STOP_ON_ERR_EN: the first failing compare
// ends the run (DONE on the next edge, step holds the failing index).
module and_test_sequencer #(
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  and_test_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_n;
  logic [3:0] step, step_n;
  logic [3:0] err, err_n;
  logic [7:0] cnt, cnt_n;
  logic       i1_q, i2_q, i1_n, i2_n;
  logic       cmp, miss_raw;

  // Vector table, entry = {i1,i2}.
  function automatic logic [1:0] vec(input logic [3:0] s);
    case (s)
      4'd0:    vec = 2'b10;
      4'd1:    vec = 2'b11;
      4'd2:    vec = 2'b01;
      4'd3:    vec = 2'b00;
      4'd4:    vec = 2'b10;
      4'd5:    vec = 2'b11;
      4'd6:    vec = 2'b01;
      4'd7:    vec = 2'b00;
      4'd8:    vec = 2'b01;
      4'd9:    vec = 2'b11;
      4'd10:   vec = 2'b01;
      default: vec = 2'b00;
    endcase
  endfunction

  // Compare only on the last dwell cycle; dut_y is don't-care elsewhere.
  // i1_q/i2_q always hold table[step] while running, so they are the expectation.
  assign cmp      = (state == RUN) && (cnt == 8'(DWELL - 1));
  assign miss_raw = cmp && (bus.dut_y != (i1_q & i2_q));

  always_comb begin
    state_n = state;
    step_n  = step;
    err_n   = err;
    cnt_n   = cnt;
    i1_n    = i1_q;
    i2_n    = i2_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n      = RUN;
          step_n       = 4'd0;
          cnt_n        = 8'd0;
          err_n        = 4'd0;
          {i1_n, i2_n} = vec(4'd0);
        end
      end
      RUN: begin
        cnt_n = cnt + 8'd1;
        if (cmp) begin
          if (miss_raw && err != 4'd15) err_n = err + 4'd1;
          cnt_n = 8'd0;
`ifdef AND_SEQ_STOP_ON_ERR_EN
          if (miss_raw || step == 4'd11) begin
`else
          if (step == 4'd11) begin
`endif
            state_n      = DONE;
            {i1_n, i2_n} = 2'b00;
          end else begin
            step_n       = step + 4'd1;
            {i1_n, i2_n} = vec(step + 4'd1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= 4'd0;
      err   <= 4'd0;
      cnt   <= 8'd0;
      i1_q  <= 1'b0;
      i2_q  <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      err   <= err_n;
      cnt   <= cnt_n;
      i1_q  <= i1_n;
      i2_q  <= i2_n;
    end
  end

  assign bus.i1        = i1_q;
  assign bus.i2        = i2_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (err == 4'd0);
  assign bus.step      = step;
  assign bus.err_count = err;
  // Suppressed under reset so an aborted run never reports a late failure.
  assign bus.mismatch  = miss_raw && !reset;

endmodule

// File: tb/tb_and_test_sequencer.sv
// tb_and_test_sequencer -- randomized scoreboard bench for and_test_sequencer.
// The gate under test is modelled as a 4-entry truth table (correct AND,
// stuck-at-0, OR, random); optional noise on dut_y outside compare cycles.
module tb_and_test_sequencer;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  and_test_sequencer_if bus();

  and_test_sequencer #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] tab [12] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11,
                           2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00};

  // Gate model: tt[{a,b}] is the gate output for inputs a,b.
  logic [3:0] tt = 4'b1000;
  logic       noise_en = 1'b0;
  logic       nz = 1'b0;
  int         rk = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    nz  <= 1'($urandom);
    if (bus.start) rk <= 0;
    else           rk <= rk + 1;
  end

  assign bus.dut_y = (noise_en && (rk % DWELL != DWELL - 1)) ? nz : tt[{bus.i1, bus.i2}];

  typedef struct {
    int done_cyc;
    int errs;
    int pass;
    int last;
    int mask;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the table, count steps where the gate differs from AND.
  function automatic exp_t model(input logic [3:0] g, input int issue_cyc);
    exp_t e;
    e.errs = 0;
    e.mask = 0;
    e.last = 11;
    for (int s = 0; s < 12; s++) begin
      logic [1:0] v;
      v = tab[s];
      if (g[v] != (v[1] & v[0])) begin
        if (e.errs < 15) e.errs++;
        e.mask |= (1 << s);
`ifdef AND_SEQ_STOP_ON_ERR_EN
        e.last = s;
        break;
`endif
      end
    end
    e.pass = (e.errs == 0) ? 1 : 0;
    e.done_cyc = issue_cyc + 1 + (e.last + 1) * DWELL;
    return e;
  endfunction

  task automatic drain(input int bound);
    int t = 0;
    while (q.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic issue_run(input logic [3:0] g, input logic nse);
    @(posedge clk);
    #1;
    tt = g;
    noise_en = nse;
    q.push_back(model(g, cyc));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_busy", bus.busy, 1);
    chk("start_done_clr", bus.done, 0);
    chk("start_pass_clr", bus.pass, 0);
    chk("start_err_clr", bus.err_count, 0);
    chk("start_step0", bus.step, 0);
    drain(12 * DWELL + 10);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_step"}, bus.step, 0);
    chk({tag, "_err"}, bus.err_count, 0);
    chk({tag, "_i1i2"}, {bus.i1, bus.i2}, 0);
    chk({tag, "_mismatch"}, bus.mismatch, 0);
  endtask

  initial begin
    bus.start = 1'b0;

    // Monitor: pops one expectation per rising done.
    fork
      begin
        int   mask = 0;
        logic prev_done = 1'b0;
        forever begin
          @(negedge clk);
          if (reset) begin
            mask = 0;
            prev_done = 1'b0;
          end else begin
            if (bus.busy && bus.done) chk("busy_done_excl", 1, 0);
            if (bus.busy) begin
              if (bus.step < 12) chk("vector", {bus.i1, bus.i2}, tab[bus.step]);
              else               chk("step_range", bus.step, 11);
            end
            if (bus.mismatch) mask |= (1 << bus.step);
            if (bus.done && !prev_done) begin
              if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
              end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("err_count", bus.err_count, e.errs);
                chk("pass", bus.pass, e.pass);
                chk("final_step", bus.step, e.last);
                chk("mismatch_steps", mask, e.mask);
                chk("done_i1i2", {bus.i1, bus.i2}, 0);
              end
              mask = 0;
            end
            prev_done = bus.done;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Directed gates: correct AND, stuck-at-0, OR
    issue_run(4'b1000, 1'b0);
    issue_run(4'b0000, 1'b0);
    issue_run(4'b1110, 1'b1);
    issue_run(4'b1000, 1'b1);

    // Randomized gates with optional dut_y noise off the compare cycle
    for (int i = 0; i < 10; i++)
      issue_run(4'($urandom_range(0, 15)), 1'($urandom));

    // Reset mid-run at step 5: abort, no done
    begin
      int t = 0;
      @(posedge clk);
      #1;
      tt = 4'b1000;
      noise_en = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      while (bus.step != 4'd5 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("reach_step5", bus.step, 5);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("abort");
      reset = 1'b0;
      repeat (2 * DWELL) @(negedge clk);
      chk("abort_no_done", bus.done, 0);
      issue_run(4'b1000, 1'b0);
    end

    // start held high across a whole run: ignored in RUN, restarts from DONE
    begin
      int n;
      @(posedge clk);
      #1;
      tt = 4'b1000;
      noise_en = 1'b0;
      n = cyc;
      q.push_back(model(4'b1000, n));
      q.push_back(model(4'b1000, n + 49));
      bus.start = 1'b1;
      while (cyc < n + 50) @(posedge clk);
      #1;
      bus.start = 1'b0;
      drain(12 * DWELL + 10);
    end

    // Failing run, then restart from DONE clears err_count
    issue_run(4'b0000, 1'b0);
    issue_run(4'b1000, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end
endmodule
